// File: rtl/usb_txn_sequencer.sv
// usb_txn_sequencer
// Transaction-level sequencer for a USB device endpoint. It takes decoded PID
// events from the RX control FSM, orders the handshake replies (OUT/DATA ->
// ACK/NAK, IN -> DATA/NAK -> wait for ACK), runs the host-response timeouts,
// and drives the TX encoder and the endpoint buffer control strobes.
//
// Ports
//   clk, n_rst        : clock, asynchronous active-low reset
//   rx_packet         : PID class from RX FSM (000 ACK, 001 OUT, 010 IN, 100 DATA, 011 error)
//   rx_pid_valid      : one-cycle strobe, rx_packet is new
//   rx_data_done      : one-cycle strobe, DATA payload stored and EOP seen
//   rx_crc_error      : payload CRC bad, valid with rx_data_done
//   buffer_occupancy  : bytes currently held in the endpoint buffer
//   tx_data_ready     : an IN payload is fully loaded
//   tx_done           : TX encoder finished the current packet
//   tx_packet         : packet to send (000 none, 001 DATA, 010 ACK, 011 NAK)
//   tx_start          : one-cycle start strobe to the TX encoder
//   d_mode            : high while the device owns the bus
//   rx_commit/rx_flush: accept / discard the received OUT payload
//   tx_commit/tx_retry: free / re-send the IN payload
//   timeout_err       : sticky timeout flag, cleared by the next rx_pid_valid
module usb_txn_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_PKT_BYTES  = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [2:0] rx_packet,
  input  logic       rx_pid_valid,
  input  logic       rx_data_done,
  input  logic       rx_crc_error,
  input  logic [6:0] buffer_occupancy,
  input  logic       tx_data_ready,
  input  logic       tx_done,
  output logic [2:0] tx_packet,
  output logic       tx_start,
  output logic       d_mode,
  output logic       rx_commit,
  output logic       rx_flush,
  output logic       tx_commit,
  output logic       tx_retry,
  output logic       timeout_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] PID_ACK  = 3'b000;
  localparam logic [2:0] PID_OUT  = 3'b001;
  localparam logic [2:0] PID_IN   = 3'b010;
  localparam logic [2:0] PID_DATA = 3'b100;

  localparam logic [2:0] TX_NONE = 3'b000;
  localparam logic [2:0] TX_DATA = 3'b001;
  localparam logic [2:0] TX_ACK  = 3'b010;
  localparam logic [2:0] TX_NAK  = 3'b011;

  typedef enum logic [2:0] {
    IDLE, OUT_WAIT, OUT_RECV, IN_DECIDE, SEND, IN_WAIT_ACK
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          rx_bad;

  assign rx_bad = rx_crc_error || (32'(buffer_occupancy) > MAX_PKT_BYTES);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      timer       <= '0;
      tx_packet   <= TX_NONE;
      tx_start    <= 1'b0;
      d_mode      <= 1'b0;
      rx_commit   <= 1'b0;
      rx_flush    <= 1'b0;
      tx_commit   <= 1'b0;
      tx_retry    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      tx_start  <= 1'b0;
      rx_commit <= 1'b0;
      rx_flush  <= 1'b0;
      tx_commit <= 1'b0;
      tx_retry  <= 1'b0;
      // Free-running saturating count; every state change below clears it.
      if (timer != '1) timer <= timer + 1'b1;
      // Any PID seen on the wire clears the sticky flag, whatever the state.
      if (rx_pid_valid) timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (rx_pid_valid && rx_packet == PID_OUT) begin
            state <= OUT_WAIT;
            timer <= '0;
          end else if (rx_pid_valid && rx_packet == PID_IN) begin
            state <= IN_DECIDE;
            timer <= '0;
          end
        end
        OUT_WAIT: begin
          if (rx_pid_valid) begin
            timer <= '0;
            if (rx_packet == PID_DATA) begin
              state <= OUT_RECV;
            end else begin
              state    <= IDLE;
              rx_flush <= 1'b1;
            end
          end else if (timer == T_LAST) begin
            state       <= IDLE;
            timer       <= '0;
            timeout_err <= 1'b1;
          end
        end
        OUT_RECV: begin
          // No timeout here: the RX FSM always delivers EOP.
          if (rx_data_done) begin
            state     <= SEND;
            timer     <= '0;
            tx_start  <= 1'b1;
            d_mode    <= 1'b1;
            tx_packet <= rx_bad ? TX_NAK : TX_ACK;
            rx_flush  <= rx_bad;
            rx_commit <= !rx_bad;
          end
        end
        IN_DECIDE: begin
          state     <= SEND;
          timer     <= '0;
          tx_start  <= 1'b1;
          d_mode    <= 1'b1;
          tx_packet <= tx_data_ready ? TX_DATA : TX_NAK;
        end
        SEND: begin
          // The bus is ours: PIDs are ignored, tx_done alone moves on.
          if (tx_done) begin
            d_mode    <= 1'b0;
            tx_packet <= TX_NONE;
            timer     <= '0;
            state     <= (tx_packet == TX_DATA) ? IN_WAIT_ACK : IDLE;
          end
        end
        IN_WAIT_ACK: begin
          if (rx_pid_valid) begin
            // A non-ACK PID ends the exchange and is not re-decoded as new.
            state     <= IDLE;
            timer     <= '0;
            tx_commit <= (rx_packet == PID_ACK);
            tx_retry  <= (rx_packet != PID_ACK);
          end else if (timer == T_LAST) begin
            state       <= IDLE;
            timer       <= '0;
            tx_retry    <= 1'b1;
            timeout_err <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_txn_sequencer.sv
// Directed bench for usb_txn_sequencer. Scenario tasks turn the spec's
// latency rules into a per-cycle expectation schedule (strobe events and
// level change points keyed by cycle number); one compare process checks
// every output against that schedule on every falling edge.
module tb_usb_txn_sequencer;
  localparam int TO  = 16;
  localparam int MAX = 64;

  localparam logic [2:0] P_ACK = 3'b000, P_OUT = 3'b001, P_IN = 3'b010,
                         P_ERR = 3'b011, P_DATA = 3'b100;
  localparam logic [2:0] T_DATA = 3'b001, T_ACK = 3'b010, T_NAK = 3'b011;

  logic       clk = 1'b0, n_rst = 1'b0;
  logic [2:0] rx_packet = '0;
  logic       rx_pid_valid = 0, rx_data_done = 0, rx_crc_error = 0;
  logic [6:0] buffer_occupancy = '0;
  logic       tx_data_ready = 0, tx_done = 0;
  logic [2:0] tx_packet;
  logic       tx_start, d_mode, rx_commit, rx_flush, tx_commit, tx_retry, timeout_err;

  usb_txn_sequencer #(.TIMEOUT_CYCLES(TO), .MAX_PKT_BYTES(MAX)) dut (
    .clk(clk), .n_rst(n_rst), .rx_packet(rx_packet), .rx_pid_valid(rx_pid_valid),
    .rx_data_done(rx_data_done), .rx_crc_error(rx_crc_error),
    .buffer_occupancy(buffer_occupancy), .tx_data_ready(tx_data_ready),
    .tx_done(tx_done), .tx_packet(tx_packet), .tx_start(tx_start), .d_mode(d_mode),
    .rx_commit(rx_commit), .rx_flush(rx_flush), .tx_commit(tx_commit),
    .tx_retry(tx_retry), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;

  // Expectation schedule: strobe events and level change points per cycle.
  bit         e_start[int], e_rcommit[int], e_rflush[int], e_tcommit[int], e_retry[int];
  logic [2:0] c_pkt[int];
  bit         c_dm[int], c_err[int];
  logic [2:0] m_pkt = '0;
  bit         m_dm = 0, m_err = 0;

  function automatic void chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (c_pkt.exists(cyc)) m_pkt = c_pkt[cyc];
    if (c_dm.exists(cyc))  m_dm  = c_dm[cyc];
    if (c_err.exists(cyc)) m_err = c_err[cyc];
    if (!n_rst) begin
      chk("rst_pkt", tx_packet, 3'b000);
      chk("rst_strobes", {tx_start, rx_commit, rx_flush}, 3'b000);
      chk("rst_strobes2", {tx_commit, tx_retry, d_mode}, 3'b000);
      chk("rst_err", {2'b00, timeout_err}, 3'b000);
    end else begin
      chk("tx_start",    {2'b00, tx_start},    {2'b00, e_start.exists(cyc)});
      chk("rx_commit",   {2'b00, rx_commit},   {2'b00, e_rcommit.exists(cyc)});
      chk("rx_flush",    {2'b00, rx_flush},    {2'b00, e_rflush.exists(cyc)});
      chk("tx_commit",   {2'b00, tx_commit},   {2'b00, e_tcommit.exists(cyc)});
      chk("tx_retry",    {2'b00, tx_retry},    {2'b00, e_retry.exists(cyc)});
      chk("tx_packet",   tx_packet,            m_pkt);
      chk("d_mode",      {2'b00, d_mode},      {2'b00, m_dm});
      chk("timeout_err", {2'b00, timeout_err}, {2'b00, m_err});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle PID; any PID clears the sticky timeout flag.
  task automatic drive_pid(input logic [2:0] p);
    int k = cyc;
    rx_packet = p; rx_pid_valid = 1'b1;
    c_err[k+1] = 1'b0;
    @(negedge clk);
    rx_pid_valid = 1'b0;
  endtask

  task automatic send_done(input bit simul);
    int k = cyc;
    tx_done = 1'b1;
    if (simul) begin
      rx_packet = P_OUT; rx_pid_valid = 1'b1; c_err[k+1] = 1'b0;
    end
    c_dm[k+1] = 1'b0; c_pkt[k+1] = 3'b000;
    @(negedge clk);
    tx_done = 1'b0; rx_pid_valid = 1'b0;
  endtask

  task automatic out_txn(input bit crc, input int occ);
    int k;
    bit bad = crc || (occ > MAX);
    drive_pid(P_OUT);
    idle(2);
    drive_pid(P_DATA);
    idle(3);
    k = cyc;
    rx_data_done = 1'b1; rx_crc_error = crc; buffer_occupancy = 7'(occ);
    if (bad) e_rflush[k+1] = 1; else e_rcommit[k+1] = 1;
    e_start[k+1] = 1; c_pkt[k+1] = bad ? T_NAK : T_ACK; c_dm[k+1] = 1'b1;
    @(negedge clk);
    rx_data_done = 1'b0; rx_crc_error = 1'b0;
    chk("lit_rsp_start", {2'b00, tx_start}, 3'b001);
    chk("lit_rsp_pkt", tx_packet, bad ? 3'b011 : 3'b010);
    idle(3);
    send_done(1'b0);
    idle(2);
  endtask

  // mode 0: host ACKs; 1: host sends another PID; 2: host silent (timeout)
  task automatic in_txn(input bit ready, input int mode, input bit stray, input bit simul);
    int k = cyc;
    tx_data_ready = ready;
    drive_pid(P_IN);
    e_start[k+2] = 1; c_dm[k+2] = 1'b1; c_pkt[k+2] = ready ? T_DATA : T_NAK;
    idle(1);
    chk("lit_in_start", {2'b00, tx_start}, 3'b001);
    chk("lit_in_pkt", tx_packet, ready ? 3'b001 : 3'b011);
    if (stray) drive_pid(P_OUT); else idle(1);
    idle(1);
    send_done(simul);
    if (!ready) begin
      idle(2);
    end else if (mode == 2) begin
      k = cyc - 1;
      e_retry[k+TO+1] = 1; c_err[k+TO+1] = 1'b1;
      idle(TO);
      chk("lit_to_retry", {2'b00, tx_retry}, 3'b001);
      chk("lit_to_err", {2'b00, timeout_err}, 3'b001);
      idle(2);
    end else begin
      idle(2);
      k = cyc;
      drive_pid(mode == 0 ? P_ACK : P_ERR);
      if (mode == 0) e_tcommit[k+1] = 1; else e_retry[k+1] = 1;
      idle(2);
    end
  endtask

  task automatic out_timeout();
    int k = cyc;
    drive_pid(P_OUT);
    c_err[k+TO+1] = 1'b1;
    idle(TO);
    chk("lit_out_to_err", {2'b00, timeout_err}, 3'b001);
    idle(3);
  endtask

  task automatic out_abort();
    int k;
    drive_pid(P_OUT);
    idle(2);
    k = cyc;
    drive_pid(P_IN);
    e_rflush[k+1] = 1;
    idle(3);
  endtask

  task automatic reset_in_send();
    int k = cyc;
    tx_data_ready = 1'b1;
    drive_pid(P_IN);
    e_start[k+2] = 1; c_dm[k+2] = 1'b1; c_pkt[k+2] = T_DATA;
    idle(2);
    #2 n_rst = 1'b0;
    c_dm[k+4] = 1'b0; c_pkt[k+4] = 3'b000; c_err[k+4] = 1'b0;
    #1;
    chk("lit_rst_dmode", {2'b00, d_mode}, 3'b000);
    chk("lit_rst_pkt", tx_packet, 3'b000);
    idle(2);
    #2 n_rst = 1'b1;
    idle(1);
  endtask

  initial begin
    idle(3);
    #2 n_rst = 1'b1;
    idle(1);
    out_txn(1'b0, 10);
    out_txn(1'b1, 10);
    out_txn(1'b0, 65);
    out_txn(1'b0, 64);
    in_txn(1'b1, 0, 1'b1, 1'b0);
    in_txn(1'b1, 2, 1'b0, 1'b0);
    out_txn(1'b0, 5);
    in_txn(1'b1, 1, 1'b0, 1'b0);
    in_txn(1'b0, 0, 1'b0, 1'b0);
    out_timeout();
    out_abort();
    rx_data_done = 1'b1;
    @(negedge clk);
    rx_data_done = 1'b0;
    idle(2);
    in_txn(1'b1, 0, 1'b0, 1'b1);
    reset_in_send();
    in_txn(1'b1, 0, 1'b0, 1'b0);
    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
